// File: rtl/fpu_sign_sched.sv
// Two-port round-robin scheduler feeding one bfloat16 sign-injection datapath,
// with a single registered result stage, tag return and an output-stall counter.

module fpu_sign_dp #(
  parameter int Std = 15,
  parameter int Exp = 7,
  parameter int Man = 6
) (
  input  logic           rst_l,
  input  logic [2:0]     op,
  input  logic [Std:0]   a,
  input  logic [Std:0]   b,
  output logic [Std:0]   y
);
  logic sgn;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    sgn = 1'b0;
    y   = '0;
    unique case (op)
      3'b001:  sgn = b[Std];
      3'b010:  sgn = ~b[Std];
      3'b100:  sgn = a[Std] ^ b[Std];
      default: sgn = 1'b0;
    endcase
    // Exponent and mantissa pass through bitwise; NaN/inf/denormals need no special case.
    if (rst_l && (op != 3'b000)) begin
      y = {sgn, a[Exp+Man+1:Man+1], a[Man:0]};
    end
  end
endmodule

module fpu_sign_sched #(
  parameter int Std  = 15,
  parameter int Exp  = 7,
  parameter int Man  = 6,
  parameter int TagW = 4,
  parameter int CntW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_funct3,
  input  logic [Std:0]    req0_a,
  input  logic [Std:0]    req0_b,
  input  logic [TagW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_funct3,
  input  logic [Std:0]    req1_a,
  input  logic [Std:0]    req1_b,
  input  logic [TagW-1:0] req1_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Std:0]    out_data,
  output logic [TagW-1:0] out_tag,
  output logic            out_port,
  output logic            out_illegal,
  output logic [CntW-1:0] stall_cnt
);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [Std:0]    data_q, data_d;
  logic [TagW-1:0] tag_q, tag_d;
  logic            port_q, port_d;
  logic            illegal_q, illegal_d;
  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;

  logic            grant0, grant1, can_accept, accept, winner;
  logic [2:0]      sel_funct3, op;
  logic [Std:0]    sel_a, sel_b, dp_y;
  logic [TagW-1:0] sel_tag;

  // Reset is folded into can_accept so no handshake completes while rst is high.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | ~rr_ptr_q);
    grant1     = req1_valid & (~req0_valid |  rr_ptr_q);
    can_accept = ~rst & ((state_q == ST_EMPTY) | out_ready);
    req0_ready = can_accept & grant0;
    req1_ready = can_accept & grant1;
    accept     = req0_ready | req1_ready;
    winner     = grant1;
  end

  always_comb begin
    sel_funct3 = winner ? req1_funct3 : req0_funct3;
    sel_a      = winner ? req1_a      : req0_a;
    sel_b      = winner ? req1_b      : req0_b;
    sel_tag    = winner ? req1_tag    : req0_tag;
    unique case (sel_funct3)
      3'b000:  op = 3'b001;
      3'b001:  op = 3'b010;
      3'b010:  op = 3'b100;
      default: op = 3'b000;
    endcase
  end

  fpu_sign_dp #(.Std(Std), .Exp(Exp), .Man(Man)) u_dp (
    .rst_l (~rst),
    .op    (op),
    .a     (sel_a),
    .b     (sel_b),
    .y     (dp_y)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    data_d      = data_q;
    tag_d       = tag_q;
    port_d      = port_q;
    illegal_d   = illegal_q;
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      state_d   = ST_FULL;
      data_d    = dp_y;
      tag_d     = sel_tag;
      port_d    = winner;
      illegal_d = (op == 3'b000);
      rr_ptr_d  = ~winner;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
    // Saturating: a long stall pins the counter instead of wrapping to a small value.
    if ((state_q == ST_FULL) && !out_ready && (stall_cnt_q != {CntW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      rr_ptr_q    <= 1'b0;
      data_q      <= '0;
      tag_q       <= '0;
      port_q      <= 1'b0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      port_q      <= port_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid   = (state_q == ST_FULL);
  assign out_data    = data_q;
  assign out_tag     = tag_q;
  assign out_port    = port_q;
  assign out_illegal = illegal_q;
  assign stall_cnt   = stall_cnt_q;
endmodule
